// File: rtl/lzss_enc_arbiter_pkg.sv
// Shared definitions for the LZSS encoder arbiter: FSM states, counter width, width helpers.
package lzss_enc_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int CNT_WIDTH = 16;

    // Ceiling log2, usable in constant expressions.
    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // A code is a flag bit plus the wider of a literal byte or an offset/length pair.
    function automatic int code_width(input int data_width, input int offset_width,
                                      input int length_width);
        int pair;
        pair = offset_width + length_width;
        return 1 + ((data_width > pair) ? data_width : pair);
    endfunction

endpackage

// File: rtl/lzss_enc_arbiter_rr.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module lzss_rr_arbiter #(
    parameter int pChannels     = 4,
    parameter int pChannelWidth = 2
) (
    input  logic [pChannels-1:0]     req,
    input  logic [pChannelWidth-1:0] last_grant,
    output logic [pChannelWidth-1:0] grant,
    output logic                     any
);

    int idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int i = 1; i <= pChannels; i++) begin
            idx = (int'(last_grant) + i) % pChannels;
            if (!any && req[pChannelWidth'(idx)]) begin
                any   = 1'b1;
                grant = pChannelWidth'(idx);
            end
        end
    end

endmodule

// File: rtl/lzss_enc_arbiter.sv
// Packet-level round-robin arbiter sharing one LZSS encoder between several byte streams.
// Optional per-channel packet counters are enabled with `define LZSS_ENC_ARB_PKT_CNT_EN.
module lzss_enc_arbiter
    import lzss_enc_arbiter_pkg::*;
#(
    parameter int pChannels       = 4,
    parameter int pDataWidth      = 8,
    parameter int pCodeWidth      = 10,
    localparam int lpChannelWidth = (log2(pChannels) > 1) ? log2(pChannels) : 1
) (
    input  logic                            clk,
    input  logic                            rst_x,
    input  logic [pChannels-1:0]            i_valid,
    output logic [pChannels-1:0]            ow_ready,
    input  logic [pChannels*pDataWidth-1:0] i_data,
    input  logic [pChannels-1:0]            i_last,
    output logic                            o_enc_valid,
    input  logic                            i_enc_ready,
    output logic [pDataWidth-1:0]           o_enc_data,
    output logic                            o_enc_last,
    input  logic                            i_enc_valid,
    output logic                            o_enc_ready,
    input  logic [pCodeWidth-1:0]           i_enc_code,
    input  logic                            i_enc_last,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [pCodeWidth-1:0]           o_code,
    output logic                            o_last,
    output logic [lpChannelWidth-1:0]       o_channel,
    output logic                            o_busy
`ifdef LZSS_ENC_ARB_PKT_CNT_EN
    ,
    output logic [pChannels*CNT_WIDTH-1:0]  o_pkt_count
`endif
);

    arb_state_t                state;
    logic [lpChannelWidth-1:0] r_grant;
    logic [lpChannelWidth-1:0] r_last_grant;
    logic [lpChannelWidth-1:0] pick;
    logic                      any_req;
    logic                      busy_q;
    logic                      data_hs;
    logic                      last_code_hs;

    lzss_rr_arbiter #(
        .pChannels    (pChannels),
        .pChannelWidth(lpChannelWidth)
    ) u_rr (
        .req       (i_valid),
        .last_grant(r_last_grant),
        .grant     (pick),
        .any       (any_req)
    );

    // Only the granted channel is steered to the encoder, and only while feeding.
    always_comb begin
        ow_ready    = '0;
        o_enc_valid = 1'b0;
        o_enc_data  = '0;
        o_enc_last  = 1'b0;
        for (int k = 0; k < pChannels; k++) begin
            if (r_grant == lpChannelWidth'(k)) begin
                o_enc_data = i_data[k*pDataWidth +: pDataWidth];
                o_enc_last = i_last[k];
                if (state == FEED) begin
                    o_enc_valid = i_valid[k];
                    ow_ready[k] = i_enc_ready;
                end
            end
        end
    end

    assign data_hs      = o_enc_valid & i_enc_ready;
    assign last_code_hs = i_enc_valid & i_ready & i_enc_last;

    assign o_valid     = i_enc_valid;
    assign o_enc_ready = i_ready;
    assign o_code      = i_enc_code;
    assign o_last      = i_enc_last;
    assign o_channel   = r_grant;
    assign o_busy      = busy_q;

    // The grant is held until the packet's final code has left downstream.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state        <= IDLE;
            r_grant      <= '0;
            r_last_grant <= lpChannelWidth'(pChannels - 1);
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        r_grant      <= pick;
                        r_last_grant <= pick;
                        state        <= FEED;
                        busy_q       <= 1'b1;
                    end
                end
                FEED: begin
                    if (data_hs && o_enc_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (last_code_hs) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef LZSS_ENC_ARB_PKT_CNT_EN
    logic [CNT_WIDTH-1:0] pkt_cnt [pChannels];

    // One count per completed packet, saturating rather than wrapping.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            for (int k = 0; k < pChannels; k++) pkt_cnt[k] <= '0;
        end else if (state == DRAIN && last_code_hs) begin
            for (int k = 0; k < pChannels; k++) begin
                if (r_grant == lpChannelWidth'(k) && pkt_cnt[k] != '1)
                    pkt_cnt[k] <= pkt_cnt[k] + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < pChannels; k++) begin : g_cnt
        assign o_pkt_count[k*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt[k];
    end
`endif

endmodule

// File: doc/lzss_enc_arbiter.md
# lzss_enc_arbiter

Packet-level round-robin arbiter that shares one LZSS encoder core between `pChannels` independent byte streams. It grants one channel at a time and forwards that channel's data into the encoder. It holds the grant until the encoder's final code for the packet has been accepted downstream, then returns the encoder to idle. Output codes are tagged with the owning channel. It sits directly in front of, and behind, the encoder top-level.

## Interface
- `pChannels`, 4, number of requesting input streams (2..16)
- `pDataWidth`, 8, input data width; must equal the encoder's data width
- `pCodeWidth`, 10, code width; must equal the encoder's code width
- `lpChannelWidth` (local), max(1, log2(`pChannels`)), channel-id width
- `clk`  in  1  clock
- `rst_x`  in  1  asynchronous reset, active low
- `i_valid`  in  `pChannels`  per-channel data valid
- `ow_ready`  out  `pChannels`  per-channel data ready
- `i_data`  in  `pChannels*pDataWidth`  channel k at bits [k*pDataWidth +: pDataWidth]
- `i_last`  in  `pChannels`  per-channel last byte of packet
- `o_enc_valid` / `i_enc_ready` / `o_enc_data[pDataWidth]` / `o_enc_last`: data to encoder
- `i_enc_valid` / `o_enc_ready` / `i_enc_code[pCodeWidth]` / `i_enc_last`: codes from encoder
- `o_valid`  out  1  tagged code valid
- `i_ready`  in  1  downstream ready
- `o_code`  out  `pCodeWidth`  code
- `o_last`  out  1  last code of packet
- `o_channel`  out  `lpChannelWidth`  channel owning `o_code`
- `o_busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, FEED, DRAIN. Reset state is IDLE.
- **IDLE.** If any `i_valid` is high, pick the first requesting channel in round-robin order, starting at `r_last_grant+1` and wrapping modulo `pChannels`. Register it as `r_grant` and set `r_last_grant <= grant`. Next state is FEED. With no request, stay in IDLE.
- **FEED.** Combinational pass-through from channel `r_grant` only:
  - `o_enc_valid = i_valid[r_grant]`
  - `o_enc_data`, `o_enc_last` are the granted channel's values
  - `ow_ready[r_grant] = i_enc_ready`
  - all other `ow_ready` bits are 0
- **FEED to DRAIN.** Occurs on a data handshake with `i_last` high.
- **DRAIN.** `o_enc_valid = 0` and all `ow_ready = 0`.
- **Code path (all states).** Combinational pass-through:
  - `o_valid = i_enc_valid`, `o_enc_ready = i_ready`
  - `o_code = i_enc_code`, `o_last = i_enc_last`
  - `o_channel = r_grant`
- **DRAIN to IDLE.** Occurs on a code handshake (`i_enc_valid & i_ready`) with `i_enc_last` high.
- A last-code handshake while in FEED is illegal; the encoder cannot produce one. The bench asserts on it, and the RTL ignores it (stays in FEED).
- Codes only arrive while a grant is held, so `o_channel` is always correct for the code it tags.
- Non-granted channels are never dropped. Their `i_valid` stays pending, with ready held low, until they are granted.

## Timing
- Reset values:
  - `ow_ready = 0`, `o_enc_valid = 0`, `o_busy = 0`
  - `r_grant = 0`, `o_channel = 0`
  - `r_last_grant = pChannels-1`, so channel 0 has first priority
  - `o_valid`, `o_code`, `o_last` follow the encoder inputs; the encoder resets them to 0
- Arbitration latency is 1 cycle. A request seen in IDLE at cycle N can be accepted no earlier than cycle N+1.
- Every return to IDLE costs at least one IDLE cycle before the next grant.
- Channel switch gap = encoder flush latency + 1 cycle.
- Simultaneous requests: round-robin order is strict, and priority rotates only on grant.
- A single-byte packet (`i_last` on the first beat) goes FEED to DRAIN after one handshake.
- Async reset mid-packet returns to IDLE immediately. The partial packet is abandoned; the encoder is reset by the same `rst_x`.
- No combinational path from `i_ready` to `ow_ready`.

## Configuration
- Macro: `LZSS_ENC_ARB_PKT_CNT_EN`.
- **Defined.** Adds output `o_pkt_count[pChannels*16]`, with one counter per channel at bits [k*16 +: 16].
  - The counter of the granted channel increments on each DRAIN-to-IDLE transition.
  - Counters saturate at 16'hFFFF and reset to 0.
- **Undefined.** The port and all counter logic are absent; behaviour is otherwise identical.

## Structure
- Shared package / function include holds:
  - FSM state encoding constants: IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2
  - `log2` and the code-width function already used by the encoder
  - the counter width constant (16)
- Sub-module `lzss_rr_arbiter`: combinational round-robin picker. Inputs are the request vector and `r_last_grant`; outputs are the grant index and `any`. The pointer register stays in the parent.

## Test plan
- **Reset, no requests.** Reset then idle with no requests → `o_busy = 0`, all `ow_ready = 0`, `o_enc_valid = 0` for 20 cycles.
- **Single-channel packet.** Channel 2 sends bytes 0x41,0x42,0x41,0x42 (last on 4th) → one IDLE cycle, then FEED. All 4 bytes reach the encoder in order, then DRAIN. Every code carries `o_channel = 2`. Return to IDLE the cycle after the last code handshake.
- **Round-robin order.** All 4 channels request 1-byte packets continuously from reset → grant order 0,1,2,3,0.
- **Back-pressure.** Channel 1 packet with `i_ready` low for 10 cycles during DRAIN → FSM stays in DRAIN, no other `ow_ready` rises, and the code is held stable until `i_ready` returns.
- **Reset mid-packet.** Assert `rst_x` low mid-FEED on channel 3 → immediate IDLE and `o_busy = 0`. After release, the first grant goes to channel 0 if it is requesting.
- **Counter feature.** With `LZSS_ENC_ARB_PKT_CNT_EN` defined, send 3 packets on channel 1 → `o_pkt_count[31:16] = 3` and all other counters are 0.
